// File: rtl/als_pkg.sv
// Shared state encoding and channel register offsets for the ambient-light-sensor reader.
package als_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_REQ  = 3'd1,
        ST_GAP  = 3'd2,
        ST_DONE = 3'd3,
        ST_FAIL = 3'd4
    } als_state_t;

    localparam logic [7:0] OFS_R = 8'd0;
    localparam logic [7:0] OFS_G = 8'd2;
    localparam logic [7:0] OFS_B = 8'd4;
    localparam logic [7:0] OFS_C = 8'd6;

    localparam logic [1:0] CH_LAST = 2'd3;

    function automatic logic [7:0] ch_offset(input logic [1:0] idx);
        case (idx)
            2'd0:    return OFS_R;
            2'd1:    return OFS_G;
            2'd2:    return OFS_B;
            default: return OFS_C;
        endcase
    endfunction

endpackage

// File: rtl/als_xfer_timer.sv
// Per-transaction ack timeout (16-bit, saturating) and per-channel retry budget.
module als_xfer_timer
    import als_pkg::*;
#(
    parameter int unsigned TIMEOUT = 50000,
    parameter int unsigned RETRIES = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic run,
    input  logic retry_clr,
    input  logic retry_inc,
    output logic timeout,
    output logic retry_left
);

    localparam logic [15:0] TMR_LAST = 16'(TIMEOUT - 1);

    logic [15:0] tmr_cnt;
    logic [7:0]  retry_cnt;

    // The FSM never goes REQ->REQ directly, so clearing while idle equals clearing on REQ entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr_cnt <= 16'd0;
        end else if (!run) begin
            tmr_cnt <= 16'd0;
        end else if (tmr_cnt != 16'hFFFF) begin
            tmr_cnt <= tmr_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            retry_cnt <= 8'd0;
        end else if (retry_clr) begin
            retry_cnt <= 8'd0;
        end else if (retry_inc && retry_cnt != 8'hFF) begin
            retry_cnt <= retry_cnt + 8'd1;
        end
    end

    assign timeout    = run && (tmr_cnt == TMR_LAST);
    assign retry_left = (32'(retry_cnt) < RETRIES);

endmodule

// File: rtl/als_reader.sv
// Reads the four ALS channel registers over the I2C master port and publishes them as one sample.
//
//  state | meaning
//  IDLE  | waiting for read_req
//  REQ   | register read outstanding for the current channel
//  GAP   | one-cycle bus_req gap between reads or before a retry
//  DONE  | sample published, data_valid pulse
//  FAIL  | retries exhausted, err set
module als_reader
    import als_pkg::*;
#(
    parameter logic [7:0]  REG_BASE = 8'h14,
    parameter int unsigned TIMEOUT  = 50000,
    parameter int unsigned RETRIES  = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        read_req,
    output logic        busy,
    output logic        bus_req,
    output logic [7:0]  bus_addr,
    input  logic        bus_ack,
    input  logic        bus_err,
    input  logic [15:0] bus_rdata,
    output logic [15:0] als_r,
    output logic [15:0] als_g,
    output logic [15:0] als_b,
    output logic [15:0] als_c,
    output logic        data_valid,
    output logic        sat,
    output logic        err
);

    als_state_t  state, state_next;
    logic [1:0]  idx, idx_next;
    logic [15:0] sh_r, sh_g, sh_b, sh_c;
    logic        timeout, retry_left;
    logic        ack_ok, xfer_bad, last_ok;

    // An ack together with bus_err is an error; an ack together with a timeout still counts.
    assign ack_ok   = (state == ST_REQ) && bus_ack && !bus_err;
    assign xfer_bad = (state == ST_REQ) && (bus_err || (timeout && !bus_ack));
    assign last_ok  = ack_ok && (idx == CH_LAST);

    als_xfer_timer #(
        .TIMEOUT (TIMEOUT),
        .RETRIES (RETRIES)
    ) u_timer (
        .clk        (clk),
        .rst        (rst),
        .run        (state == ST_REQ),
        .retry_clr  ((state == ST_IDLE) || ack_ok),
        .retry_inc  (xfer_bad && retry_left),
        .timeout    (timeout),
        .retry_left (retry_left)
    );

    always_comb begin
        state_next = state;
        idx_next   = idx;
        case (state)
            ST_IDLE: begin
                idx_next = 2'd0;
                if (read_req) state_next = ST_REQ;
            end
            ST_REQ: begin
                if (ack_ok) begin
                    if (idx == CH_LAST) begin
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_GAP;
                        idx_next   = idx + 2'd1;
                    end
                end else if (xfer_bad) begin
                    state_next = retry_left ? ST_GAP : ST_FAIL;
                end
            end
            ST_GAP:  state_next = ST_REQ;
            ST_DONE: state_next = ST_IDLE;
            ST_FAIL: state_next = ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // Outputs are registered from the next state so they line up with the state they describe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            idx        <= 2'd0;
            busy       <= 1'b0;
            bus_req    <= 1'b0;
            bus_addr   <= 8'd0;
            data_valid <= 1'b0;
            sat        <= 1'b0;
            err        <= 1'b0;
            als_r      <= 16'd0;
            als_g      <= 16'd0;
            als_b      <= 16'd0;
            als_c      <= 16'd0;
            sh_r       <= 16'd0;
            sh_g       <= 16'd0;
            sh_b       <= 16'd0;
            sh_c       <= 16'd0;
        end else begin
            state      <= state_next;
            idx        <= idx_next;
            busy       <= (state_next != ST_IDLE);
            bus_req    <= (state_next == ST_REQ);
            data_valid <= 1'b0;
            if (state_next == ST_REQ && state != ST_REQ) begin
                bus_addr <= REG_BASE + ch_offset(idx_next);
            end
            if (ack_ok) begin
                case (idx)
                    2'd0:    sh_r <= bus_rdata;
                    2'd1:    sh_g <= bus_rdata;
                    2'd2:    sh_b <= bus_rdata;
                    default: sh_c <= bus_rdata;
                endcase
            end
            // The C value bypasses its shadow so all four channels appear together in DONE.
            if (last_ok) begin
                als_r      <= sh_r;
                als_g      <= sh_g;
                als_b      <= sh_b;
                als_c      <= bus_rdata;
                sat        <= (bus_rdata == 16'hFFFF);
                err        <= 1'b0;
                data_valid <= 1'b1;
            end
            if (xfer_bad && !retry_left) begin
                err <= 1'b1;
            end
        end
    end

endmodule

// File: doc/als_reader.md
ALS_READER -- requirements
Module: als_reader

Interface
REQ-001 SHALL have parameter REG_BASE, default 8'h14, meaning register address of the first channel (R); G, B and C are at +2, +4 and +6.
REQ-002 SHALL have parameter TIMEOUT, default 50000, meaning the maximum cycles to wait for bus_ack per transaction.
REQ-003 SHALL have parameter RETRIES, default 2, meaning the extra attempts allowed per channel after an error or timeout.
REQ-004 SHALL use one clock and a synchronous, active-high reset. Ports, one per line:
  clk  in  1  system clock (50 MHz)
  rst  in  1  synchronous active-high reset
  read_req  in  1  one-cycle request to sample the sensor, from the control unit
  busy  out  1  sample sequence in progress
  bus_req  out  1  register-read request to the I2C master, level
  bus_addr  out  8  register address for the current read
  bus_ack  in  1  one-cycle completion from the I2C master; bus_rdata valid in the same cycle
  bus_err  in  1  one-cycle NACK/error from the I2C master
  bus_rdata  in  16  register read data
  als_r, als_g, als_b, als_c  out  16 each  last good channel values
  data_valid  out  1  one-cycle pulse when all four channels are updated
  sat  out  1  als_c of the last good sample equals 16'hFFFF
  err  out  1  sticky failure flag; cleared by the next successful sample

Function
REQ-005 SHALL implement the states IDLE, REQ, GAP, DONE and FAIL.
REQ-006 IDLE: read_req=1 -> REQ on the next cycle; channel index=0; retry count=0.
REQ-007 REQ: bus_req=1 and bus_addr=REG_BASE+2*index, both registered and stable until exit.
REQ-008 REQ, bus_ack=1: capture bus_rdata into the shadow register for the current index.
REQ-009 REQ, bus_ack=1, index<3: go to GAP and increment index; index==3: go to DONE.
REQ-010 REQ, bus_err=1 or timeout counter reaching TIMEOUT-1 without ack: if retries<RETRIES, increment retries and go to GAP, keeping the same index; otherwise go to FAIL.
REQ-011 REQ, bus_ack and bus_err both high in the same cycle: treat as an error.
REQ-012 REQ, bus_ack and timeout in the same cycle: ack wins.
REQ-013 The retry count SHALL reset to 0 on every successful channel read.
REQ-014 GAP SHALL last exactly one cycle with bus_req=0, then return to REQ; the timeout counter SHALL be cleared on entry to REQ.
REQ-015 DONE SHALL last one cycle: copy all shadow registers to als_r/g/b/c together, pulse data_valid, update sat, clear err, then go to IDLE.
REQ-016 FAIL SHALL last one cycle: set err, leave outputs and sat unchanged, give no data_valid, then go to IDLE.
REQ-017 busy SHALL equal 1 in every state except IDLE, registered.
REQ-018 busy SHALL go high the cycle after read_req is accepted and go low the cycle after DONE or FAIL.
REQ-019 read_req SHALL be ignored while busy=1; no queuing.
REQ-020 bus_ack and bus_err SHALL be ignored outside REQ.
REQ-021 Latency with a zero-wait master (ack in the first REQ cycle): read_req at cycle 0 -> REQ at cycles 1, 3, 5, 7 -> data_valid at cycle 8 -> busy=0 at cycle 9.
REQ-022 The timeout counter SHALL be 16 bits wide and saturate; no wrap.

Reset
REQ-023 rst SHALL force state=IDLE on the next edge, including mid-transaction.
REQ-024 rst SHALL drive bus_req=0, bus_addr=0, busy=0, data_valid=0, sat=0, err=0, als_r/g/b/c=0, shadow registers=0, and clear all counters.

Structure
REQ-025 State encodings and the channel offset constants (0, 2, 4, 6) SHALL live in the shared package als_pkg.
REQ-026 The per-transaction timeout/retry logic MAY be the sub-module als_xfer_timer; everything else SHALL be flat.

Verification
REQ-027 Zero-wait master returning R=0x0100, G=0x0200, B=0x0300, C=0x0400 -> data_valid at cycle 8 with those values; busy high for cycles 1-8.
REQ-028 bus_err on the G read once, then ack 0x0222 -> G address 0x16 re-issued after a one-cycle gap; data_valid with G=0x0222; err=0.
REQ-029 No ack on the B read for 3 x TIMEOUT cycles (TIMEOUT=16) -> FAIL, err=1, no data_valid, outputs keep the prior sample.
REQ-030 A following good read after REQ-029 -> err cleared; C=0xFFFF gives sat=1.
REQ-031 read_req pulsed at cycles 2 and 4 during busy -> ignored; exactly one data_valid.
REQ-032 rst asserted in REQ for the C read -> bus_req=0 and all outputs zero on the next cycle; a new read_req starts at R (address 0x14).
